// File: rtl/mem_ctrl_sp.sv
// rtl/mem_ctrl_sp.sv - single-port data memory with clear sequencer, latency and byte lanes
//
// Purpose:
//   Single-port synchronous data memory between the load/store unit and the
//   data store. After reset a sequencer clears every word (INIT). The block
//   then accepts one request at a time through a start/rwn handshake. Each
//   access completes LATENCY edges after it is accepted. Writes use per-byte
//   lane enables. Addresses >= DEPTH never touch memory, and reads of them
//   return 0.
//
// Optional feature:
//   MEM_RANGE_ERR_EN - when defined, err flags out-of-range accesses in their
//   done cycle. When undefined, err is tied to 0.
//
// Ports:
//   clk       in   clock, rising edge active
//   reset     in   synchronous active-high reset
//   start     in   request strobe, sampled only while ready=1
//   rwn       in   1 = read, 0 = write
//   address   in   [ADDR_W-1:0] word address
//   data_in   in   [DATA_W-1:0] write data
//   byte_en   in   [DATA_W/8-1:0] write lane enables
//   data_out  out  [DATA_W-1:0] read data, held until the next read commits
//   ready     out  idle and able to accept start
//   done      out  one-cycle completion pulse
//   err       out  out-of-range flag, valid only with done
module mem_ctrl_sp #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rwn,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     data_out,
  output logic                  ready,
  output logic                  done,
  output logic                  err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  clr_cnt;
  logic [LAT_W-1:0]  lat_cnt;

  logic [ADDR_W-1:0] req_addr;
  logic              req_rwn;
  logic [DATA_W-1:0] req_data;
  logic [NB-1:0]     req_be;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              in_range;
  logic [IDX_W-1:0]  req_idx;
  logic              commit;

  // Range check is done on the full address so nothing ever wraps modulo DEPTH.
  assign in_range = (32'(req_addr) < DEPTH_U);
  assign req_idx  = IDX_W'(req_addr);
  assign commit   = (state == ST_WAIT) && (lat_cnt == '0);
  assign ready    = (state == ST_IDLE);

  // Single memory write port shared by the clear sequencer and write commits.
  // Gated by reset so an uncommitted write is discarded on a reset edge.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_wdata = req_data;
    mem_be    = req_be;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_idx   = clr_cnt;
        mem_wdata = '0;
        mem_be    = '1;
      end else if (commit && !req_rwn && in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      clr_cnt  <= '0;
      lat_cnt  <= '0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (start) begin
            req_addr <= address;
            req_rwn  <= rwn;
            req_data <= data_in;
            req_be   <= byte_en;
            lat_cnt  <= LAT_W'(LATENCY - 1);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
            if (req_rwn) begin
              data_out <= in_range ? mem[req_idx] : '0;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef MEM_RANGE_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= commit && !in_range;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mem_ctrl_sp.md
Name: mem_ctrl_sp

Overview:
- Parametrised single-port synchronous data memory with a start/rwn request handshake, a configurable access latency, and byte-lane write enables.
- Successor to the team's fixed 4K x 32 memory. Adds a hardware clear sequencer after reset, a ready/done handshake, and defined handling of out-of-range addresses.
- Sits between the datapath load/store unit and the data store.

Parameters:
- DATA_W, 32: word width in bits. Must be a multiple of 8.
- DEPTH, 4096: number of words. Need not be a power of two.
- ADDR_W, 16: width of the address port.
- LATENCY, 2: cycles from request acceptance to done. Must be at least 1.

Ports:
- clk  input  1  clock. Rising edge is active.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request strobe. Sampled only while ready=1.
- rwn  input  1  1 = read, 0 = write.
- address  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- byte_en  input  DATA_W/8  write lane enables. Bit i enables data_in[8i+7:8i].
- data_out  output  DATA_W  read data.
- ready  output  1  block is idle and will accept start.
- done  output  1  one-cycle pulse marking completion of an access.
- err  output  1  out-of-range flag. Valid only with done.

Behaviour:
- One clock domain. All state updates on the rising edge of clk.
- reset (synchronous, active-high), sampled on an edge with reset=1:
  - state goes to INIT, clear counter goes to 0.
  - data_out=0, done=0, err=0, ready=0.
  - Overrides every other input, including in-flight requests.
- INIT state:
  - Writes 0 to word[cnt] each cycle, cnt = 0..DEPTH-1.
  - After the edge that clears word DEPTH-1, moves to IDLE.
  - ready=1 in the first cycle of IDLE. That is DEPTH cycles after the first edge with reset=0.
  - start is ignored during INIT.
- IDLE state: ready=1.
  - On an edge with start=1, latch address, rwn, data_in and byte_en into request registers.
  - Then move to WAIT with the latency counter set to LATENCY-1. ready drops in the next cycle.
  - Inputs may change after the acceptance edge without effect.
- WAIT state:
  - The latency counter decrements each edge.
  - On the edge where the counter is 0, the access commits and done=1 for exactly the following cycle. The state returns to IDLE at that same edge.
  - Result: done is high in the cycle that begins LATENCY edges after the acceptance edge.
  - ready and done are both 1 in that cycle. A start there is accepted, giving back-to-back throughput of one access per LATENCY+1 cycles.
- Read commit:
  - data_out takes word[addr] at the commit edge.
  - data_out holds its value until the next read commits. Writes never change data_out.
- Write commit:
  - For each lane i with byte_en[i]=1, word[addr] lane i takes data_in lane i. Lanes with byte_en[i]=0 are unchanged.
  - byte_en=0 makes the write a no-op that still returns done.
- start in a cycle with ready=0 is ignored. It is not queued.
- Reset mid-access: an uncommitted write is discarded, and memory is cleared anyway by INIT.
- Out-of-range addresses (address >= DEPTH):
  - A write modifies no word.
  - A read returns 0 on data_out.
  - done still pulses.
  - err behaviour is given under Optional Feature.
- The top address DEPTH-1 is legal. No wrap-around: addresses are never reduced modulo DEPTH.

Optional Feature:
- Macro: MEM_RANGE_ERR_EN.
- Defined: err=1 in the done cycle of any access whose address >= DEPTH, otherwise err=0. err is 0 in every cycle where done=0.
- Not defined: err is tied to 0. Out-of-range accesses behave as in Behaviour but are not flagged.

Test Plan:
- Clear sequence:
  - Stimulus: assert reset for 3 cycles, deassert, wait for ready.
  - Required: ready rises exactly DEPTH (4096) cycles after reset release.
  - Required: reads of addresses 0, 2047 and 4095 return 0x00000000.
- Write then read, LATENCY=2:
  - Stimulus: write 0xDEADBEEF to address 0x0010 with byte_en=0xF, then read 0x0010.
  - Required: each done pulse comes 2 cycles after its start edge.
  - Required: data_out=0xDEADBEEF.
- Byte lanes:
  - Stimulus: after the previous test, write 0x11223344 to 0x0010 with byte_en=0x5.
  - Required: a read returns 0xDE22BE44.
- Ignored start and back-to-back:
  - Stimulus: pulse start while ready=0 with a write of 0xFFFFFFFF to address 0x0020.
  - Required: no done pulse and word 0x20 stays 0.
  - Stimulus: issue start in the done cycle.
  - Required: that start is accepted.
- Out of range:
  - Stimulus: write 0x12345678 to address 4096, then read 4096.
  - Required: data_out=0.
  - Required: err=1 on both done pulses with MEM_RANGE_ERR_EN, err=0 without it.
  - Required: word 0 is unchanged.
- Reset mid-access:
  - Stimulus: start a write of 0xCAFEF00D to 0x0005 and assert reset one cycle later.
  - Required: no done pulse.
  - Required: after INIT, a read of 0x0005 returns 0.
